mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters SHALL be: none; the data width is fixed at 32 bits and the register address at 5 bits.
REQ-002 Port clk, input, 1, sole clock; every state element updates on its rising edge.
REQ-003 Port rst, input, 1, reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-004 Ports from EX_MEM SHALL be inputs: ram_en 1, ram_write_en 1, ram_write_sel 4, ram_write_data 32, load_type 3, result 32, write_reg_en 1, write_reg_addr 5, write_hilo_en 1, write_hi_data 32, write_lo_data 32.
  - result carries the effective address for memory operations.
REQ-005 Port hold_in, input, 1: a later stage is stalled, so this stage must keep its current output.
REQ-006 Data bus ports SHALL be:
  - outputs: data_req 1, data_wr 1, data_wstrb 4, data_addr 32, data_wdata 32;
  - inputs: data_addr_ok 1, data_data_ok 1, data_rdata 32.
REQ-007 Ports to MEM_WB SHALL be outputs: result_out 32, write_reg_en_out 1, write_reg_addr_out 5, write_hilo_en_out 1, write_hi_data_out 32, write_lo_data_out 32.
REQ-008 Port stall_request, output, 1: request to stall the current and all earlier stages.

Function
REQ-009 The FSM SHALL have four states: IDLE, ADDR, DATA and DONE.
REQ-010 In IDLE with ram_en=0, the block SHALL:
  - hold data_req=0 and stall_request=0;
  - drive result_out=result;
  - remain in IDLE.
REQ-011 In IDLE with ram_en=1, the block SHALL assert data_req=1 and stall_request=1 in the same cycle.
  - Next state is DATA if data_addr_ok=1, otherwise ADDR.
REQ-012 In ADDR, the block SHALL hold data_req=1 with all request fields unchanged until data_addr_ok=1, then go to DATA; stall_request=1.
REQ-013 In DATA, the block SHALL drive data_req=0 and stall_request=1.
  - On data_data_ok=1 it captures data_rdata into rdata_buf and goes to DONE.
REQ-014 In DONE, the block SHALL drive stall_request=0 and data_req=0.
  - It goes to IDLE when hold_in=0 and stays in DONE while hold_in=1.
REQ-015 The request fields SHALL be:
  - data_wr=ram_write_en;
  - data_addr={result[31:2],2'b00};
  - data_wstrb = ram_write_sel for stores and 4'b0000 for loads;
  - data_wdata=ram_write_data.
REQ-016 data_data_ok SHALL be ignored outside DATA, and data_addr_ok SHALL be ignored outside IDLE and ADDR.
  - A data_ok arriving in the same cycle as addr_ok is ignored.
REQ-017 load_type encodings SHALL be: 0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; values 5-7 are treated as LW.
REQ-018 Load extraction from rdata_buf SHALL be:
  - byte = rdata_buf[8*a+7:8*a], where a=result[1:0];
  - half = rdata_buf[16*result[1]+15:16*result[1]];
  - LB and LH sign-extend, LBU and LHU zero-extend.
REQ-019 result_out SHALL be the extracted load value in DONE when ram_write_en=0; otherwise result_out=result.
REQ-020 The write_reg, write_hilo, hi and lo outputs SHALL pass through combinationally from their inputs in every state.
REQ-021 Memory latency SHALL be at least 2 cycles (IDLE to DATA to DONE); the instruction leaves in the cycle after DONE is entered.
REQ-022 The block SHALL NOT accept back-to-back requests: a new request is issued only from IDLE.
  - A memory instruction presented in DONE is serviced after the return to IDLE.

Reset
REQ-023 While rst=0 at a clock edge, the block SHALL set state to IDLE and rdata_buf to 0.
  - An in-flight transaction is abandoned and its late data_ok is ignored under REQ-016.
REQ-024 While state=IDLE after reset, the outputs SHALL be data_req=0 (with ram_en=0), stall_request=0, and result_out=result.

Verification
REQ-025 ALU passthrough: ram_en=0, result=0x12345678 -> result_out=0x12345678, stall_request=0, data_req=0 in every cycle.
REQ-026 LW with addr_ok in the first cycle and data_ok 2 cycles later, rdata=0xDEADBEEF.
  - Required: stall_request=1 for 3 cycles, then 0 in DONE.
  - Required: result_out=0xDEADBEEF.
REQ-027 LB at address 0x1003 with rdata=0x80FF7F01 -> result_out=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-028 SW at address 0x2006 with sel=4'b1100 and addr_ok delayed 3 cycles.
  - Required: data_req is held 4 cycles with data_addr=0x2004, data_wstrb=4'b1100 and data_wr=1.
  - Required: after data_ok, the block enters DONE.
REQ-029 DONE with hold_in=1 for 2 cycles -> the block stays in DONE with result_out stable and no new data_req; it goes to IDLE after hold_in falls.
REQ-030 rst=0 asserted in DATA -> IDLE next cycle; a subsequent data_ok with no request pending does not change result_out or state.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM stage sequencing one load/store at a time over an addr_ok/data_ok data bus.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic        ram_write_en,
  input  logic [3:0]  ram_write_sel,
  input  logic [31:0] ram_write_data,
  input  logic [2:0]  load_type,
  input  logic [31:0] result,
  input  logic        write_reg_en,
  input  logic [4:0]  write_reg_addr,
  input  logic        write_hilo_en,
  input  logic [31:0] write_hi_data,
  input  logic [31:0] write_lo_data,
  input  logic        hold_in,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] result_out,
  output logic        write_reg_en_out,
  output logic [4:0]  write_reg_addr_out,
  output logic        write_hilo_en_out,
  output logic [31:0] write_hi_data_out,
  output logic [31:0] write_lo_data_out,
  output logic        stall_request
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_rdata_buf;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rdata_buf <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DATA && data_data_ok) r_rdata_buf <= data_rdata;
    end
  end
  always_comb begin
    w_next        = r_state;
    data_req      = 1'b0;
    stall_request = 1'b0;
    case (r_state)
      IDLE: begin
        data_req      = ram_en;
        stall_request = ram_en;
        w_next        = ram_en ? (data_addr_ok ? DATA : ADDR) : IDLE;
      end
      ADDR: begin
        data_req      = 1'b1;
        stall_request = 1'b1;
        w_next        = data_addr_ok ? DATA : ADDR;
      end
      DATA: begin
        stall_request = 1'b1;
        w_next        = data_data_ok ? DONE : DATA;
      end
      default: w_next = hold_in ? DONE : IDLE;
    endcase
  end
  assign data_wr    = ram_write_en;
  assign data_addr  = {result[31:2], 2'b00};
  assign data_wstrb = ram_write_en ? ram_write_sel : 4'b0000;
  assign data_wdata = ram_write_data;
  assign w_byte = r_rdata_buf[{result[1:0], 3'b000} +: 8];
  assign w_half = r_rdata_buf[{result[1], 4'b0000} +: 16];
  // Encodings 5-7 fall through to a full-word load.
  assign w_load = load_type == 3'd1 ? {{24{w_byte[7]}}, w_byte} :
                  load_type == 3'd2 ? {24'b0, w_byte} :
                  load_type == 3'd3 ? {{16{w_half[15]}}, w_half} :
                  load_type == 3'd4 ? {16'b0, w_half} : r_rdata_buf;
  assign result_out         = (r_state == DONE && !ram_write_en) ? w_load : result;
  assign write_reg_en_out   = write_reg_en;
  assign write_reg_addr_out = write_reg_addr;
  assign write_hilo_en_out  = write_hilo_en;
  assign write_hi_data_out  = write_hi_data;
  assign write_lo_data_out  = write_lo_data;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed load/store/stall/reset vectors with a result_out scoreboard.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_en = 1'b0, ram_write_en = 1'b0;
  logic [3:0]  ram_write_sel = '0;
  logic [31:0] ram_write_data = '0;
  logic [2:0]  load_type = '0;
  logic [31:0] result = '0;
  logic        write_reg_en = 1'b0;
  logic [4:0]  write_reg_addr = '0;
  logic        write_hilo_en = 1'b0;
  logic [31:0] write_hi_data = '0, write_lo_data = '0;
  logic        hold_in = 1'b0;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic        write_hilo_en_out;
  logic [31:0] write_hi_data_out, write_lo_data_out;
  logic        stall_request;
  int checks = 0, failures = 0;
  logic [31:0] sb[$];
  logic prev_stall = 1'b0;

  mem_access dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
    .ram_write_sel(ram_write_sel), .ram_write_data(ram_write_data), .load_type(load_type),
    .result(result), .write_reg_en(write_reg_en), .write_reg_addr(write_reg_addr),
    .write_hilo_en(write_hilo_en), .write_hi_data(write_hi_data), .write_lo_data(write_lo_data),
    .hold_in(hold_in), .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .result_out(result_out),
    .write_reg_en_out(write_reg_en_out), .write_reg_addr_out(write_reg_addr_out),
    .write_hilo_en_out(write_hilo_en_out), .write_hi_data_out(write_hi_data_out),
    .write_lo_data_out(write_lo_data_out), .stall_request(stall_request)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  // A stall falling edge outside reset marks entry into DONE: the instruction result is presented.
  always @(negedge clk) begin
    if (rst && prev_stall && !stall_request) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h exp=none", result_out);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (result_out !== e) begin
          failures++;
          $display("FAIL sb_result got=%h exp=%h", result_out, e);
        end
      end
    end
    prev_stall = rst ? stall_request : 1'b0;
  end

  task automatic access(input string n, input logic we, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [2:0] lt, input logic [31:0] addr,
                        input int aw, input int dl, input logic [31:0] rd, input int hold,
                        input logic [31:0] exp);
    int nreq = 0, nstall = 0;
    @(posedge clk); #1;
    ram_en = 1'b1; ram_write_en = we; ram_write_sel = sel; ram_write_data = wd;
    load_type = lt; result = addr;
    sb.push_back(exp);
    for (int c = 0; c <= aw + dl; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      data_addr_ok = (c == aw);
      data_data_ok = (c == aw) || (c == aw + dl);
      data_rdata   = (c == aw + dl) ? rd : 32'hBAD0BAD0;
      @(negedge clk);
      if (data_req) begin
        nreq++;
        chk({n, "_req"}, {data_wr, data_wstrb, data_addr, data_wdata},
            {we, we ? sel : 4'h0, addr[31:2], 2'b00, wd});
      end
      if (stall_request) nstall++;
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      hold_in = (h < hold);
      @(negedge clk);
      chk({n, "_done"}, {stall_request, data_req, result_out}, {2'b00, exp});
    end
    chk({n, "_nreq"}, nreq, aw + 1);
    chk({n, "_nstall"}, nstall, aw + dl + 1);
    @(posedge clk); #1;
    ram_en = 1'b0; hold_in = 1'b0; ram_write_en = 1'b0;
    @(negedge clk);
    chk({n, "_idle"}, {stall_request, data_req, result_out}, {2'b00, addr});
  endtask

  initial begin
    result = 32'h0000CAFE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_state", {stall_request, data_req, result_out}, {2'b00, 32'h0000CAFE});
    @(posedge clk); #1;
    result = 32'h12345678; write_reg_en = 1'b1; write_reg_addr = 5'd17;
    write_hilo_en = 1'b1; write_hi_data = 32'hA5A5A5A5; write_lo_data = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_pass", {stall_request, data_req, result_out}, {2'b00, 32'h12345678});
    end
    chk("passthru", {write_reg_en_out, write_reg_addr_out, write_hilo_en_out, write_hi_data_out, write_lo_data_out},
        {1'b1, 5'd17, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A});
    access("lw",   1'b0, 4'hF, 32'h0,        3'd0, 32'h00000100, 0, 2, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    access("lb",   1'b0, 4'hF, 32'h0,        3'd1, 32'h00001003, 0, 1, 32'h80FF7F01, 0, 32'hFFFFFF80);
    access("lbu",  1'b0, 4'hF, 32'h0,        3'd2, 32'h00001003, 1, 1, 32'h80FF7F01, 0, 32'h00000080);
    access("lb1",  1'b0, 4'h0, 32'h0,        3'd1, 32'h00001001, 0, 1, 32'h80FF7F01, 0, 32'h0000007F);
    access("lh",   1'b0, 4'h0, 32'h0,        3'd3, 32'h00001002, 0, 1, 32'h80FF7F01, 0, 32'hFFFF80FF);
    access("lhu",  1'b0, 4'h0, 32'h0,        3'd4, 32'h00001000, 2, 1, 32'h80FF7F01, 0, 32'h00007F01);
    access("lt7",  1'b0, 4'h0, 32'h0,        3'd7, 32'h00003001, 0, 1, 32'h11223344, 0, 32'h11223344);
    access("sw",   1'b1, 4'hC, 32'hCAFEF00D, 3'd0, 32'h00002006, 3, 1, 32'h0,        0, 32'h00002006);
    access("hold", 1'b0, 4'h0, 32'h0,        3'd0, 32'h00000200, 0, 1, 32'h0BADF00D, 2, 32'h0BADF00D);
    // Reset while waiting for data; the stale data_ok afterwards must be ignored.
    @(posedge clk); #1;
    ram_en = 1'b1; load_type = 3'd0; result = 32'h00000300; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; rst = 1'b0; ram_en = 1'b0; result = 32'h00000055;
    @(negedge clk);
    chk("rst_data_stall", stall_request, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", {stall_request, data_req, result_out}, {2'b00, 32'h00000055});
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hAAAAAAAA;
    @(negedge clk);
    chk("late_ok", {stall_request, data_req, result_out}, {2'b00, 32'h00000055});
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("late_ok_after", {stall_request, data_req, result_out}, {2'b00, 32'h00000055});
    access("post_rst", 1'b0, 4'h0, 32'h0, 3'd2, 32'h00000402, 0, 1, 32'h00C30000, 0, 32'h000000C3);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
